// File: rtl/divide_seq.sv
// divide_seq: iterative radix-2 restoring divider producing quotient and
// remainder of two DATA_WIDTH operands, one result bit per clock, with a
// valid/ready handshake on both sides and one operation in flight.
//
// Optional build macro: DIVIDE_SEQ_SIGNED_EN
//   undefined (default) - unsigned operands, no sign logic at all
//   defined             - two's complement operands; magnitudes are divided
//                         and signs restored on the way into DONE, so the
//                         latency is identical to the unsigned build.
module divide_seq #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_by_zero
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_ITER = CW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state;
   logic [CW-1:0]         count;
   // Remaining dividend bits leave at the top while quotient bits enter at
   // the bottom, so after the last iteration this register is the quotient.
   logic [DATA_WIDTH-1:0] work;
   logic [DATA_WIDTH:0]   part_rem;
   logic [DATA_WIDTH-1:0] dsr;

   logic [DATA_WIDTH:0]   shifted;
   logic [DATA_WIDTH:0]   trial;
   logic                  fits;
   logic [DATA_WIDTH:0]   rem_next;
   logic [DATA_WIDTH-1:0] work_next;

   logic [DATA_WIDTH-1:0] dvd_mag;
   logic [DATA_WIDTH-1:0] dsr_mag;
   logic [DATA_WIDTH-1:0] final_q;
   logic [DATA_WIDTH-1:0] final_r;
   logic [DATA_WIDTH-1:0] dz_q;

   // Handshake flags are decoded straight from the state register so there is
   // no combinational path from in_valid or out_ready to either of them.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // One restoring step: shift in the next dividend bit, subtract the divisor
   // if it fits and record whether it did as the next quotient bit.
   always_comb begin
      shifted   = {part_rem[DATA_WIDTH-1:0], work[DATA_WIDTH-1]};
      trial     = shifted - {1'b0, dsr};
      fits      = (shifted >= {1'b0, dsr});
      rem_next  = fits ? trial : shifted;
      work_next = {work[DATA_WIDTH-2:0], fits};
   end

`ifdef DIVIDE_SEQ_SIGNED_EN
   logic neg_q;
   logic neg_r;

   // Operand magnitudes going in and sign restoration coming out; the most
   // negative value negates to itself, which is exactly its magnitude.
   always_comb begin
      dvd_mag = dividend[DATA_WIDTH-1] ? -dividend : dividend;
      dsr_mag = divisor[DATA_WIDTH-1]  ? -divisor  : divisor;
      final_q = neg_q ? -work_next : work_next;
      final_r = neg_r ? -rem_next[DATA_WIDTH-1:0] : rem_next[DATA_WIDTH-1:0];
      dz_q    = dividend[DATA_WIDTH-1] ? DATA_WIDTH'(1) : '1;
   end

   // Result signs are captured with the operands: quotient is negative when
   // the operand signs differ, remainder follows the dividend.
   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q <= 1'b0;
         neg_r <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         neg_q <= dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1];
         neg_r <= dividend[DATA_WIDTH-1];
      end
   end
`else
   // Unsigned build: operands and results pass through untouched.
   always_comb begin
      dvd_mag = dividend;
      dsr_mag = divisor;
      final_q = work_next;
      final_r = rem_next[DATA_WIDTH-1:0];
      dz_q    = '1;
   end
`endif

   // Control FSM with the datapath registers: accept in IDLE, iterate
   // DATA_WIDTH times in CALC, present and hold the result in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         count       <= '0;
         work        <= '0;
         part_rem    <= '0;
         dsr         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (divisor == '0) begin
                     quotient    <= dz_q;
                     remainder   <= dividend;
                     div_by_zero <= 1'b1;
                     state       <= DONE;
                  end else begin
                     work     <= dvd_mag;
                     dsr      <= dsr_mag;
                     part_rem <= '0;
                     count    <= '0;
                     state    <= CALC;
                  end
               end
            end
            CALC: begin
               part_rem <= rem_next;
               work     <= work_next;
               if (count == LAST_ITER) begin
                  quotient    <= final_q;
                  remainder   <= final_r;
                  div_by_zero <= 1'b0;
                  count       <= '0;
                  state       <= DONE;
               end else begin
                  count <= count + CNT_ONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
